// File: rtl/tbox_lookup_arbiter_if.sv
// rtl/tbox_lookup_arbiter_if.sv - request/ROM/response bundle for the shared Te-table arbiter
//
// Purpose: groups every non-clock/reset signal of tbox_lookup_arbiter.
//   slave  : the arbiter side (takes requests and rom_q, drives grants, rom_addr, responses).
//   master : the environment side (requesters, ROM instance, statistics reader).
// Signals:
//   en           arbitration enable
//   req_valid    [N]      per-requester request valid
//   req_addr     [8N]     per-requester table index, requester i at [8i+7:8i]
//   req_rot      [2N]     per-requester rotation select, requester i at [2i+1:2i]
//   req_ready    [N]      one-hot grant
//   rom_addr     [8]      ROM address
//   rom_q        [32]     ROM data, one cycle after rom_addr
//   rsp_valid/rsp_id/rsp_data  tagged, rotated lookup result
//   stat_clr     synchronous clear of lookup_count
//   lookup_count [16]     saturating granted-lookup counter
interface tbox_lookup_arbiter_if #(
  parameter int N    = 4,
  parameter int ID_W = 2
);
  logic              en;
  logic [N-1:0]      req_valid;
  logic [8*N-1:0]    req_addr;
  logic [2*N-1:0]    req_rot;
  logic [N-1:0]      req_ready;
  logic [7:0]        rom_addr;
  logic [31:0]       rom_q;
  logic              rsp_valid;
  logic [ID_W-1:0]   rsp_id;
  logic [31:0]       rsp_data;
  logic              stat_clr;
  logic [15:0]       lookup_count;

  modport slave (
    input  en, req_valid, req_addr, req_rot, rom_q, stat_clr,
    output req_ready, rom_addr, rsp_valid, rsp_id, rsp_data, lookup_count
  );

  modport master (
    output en, req_valid, req_addr, req_rot, rom_q, stat_clr,
    input  req_ready, rom_addr, rsp_valid, rsp_id, rsp_data, lookup_count
  );
endinterface

// File: rtl/tbox_lookup_arbiter.sv
// rtl/tbox_lookup_arbiter.sv - round-robin sharing of one Te-table ROM among N requesters
//
// Purpose: grants one table lookup per cycle round-robin, drives the single
//   ROM, rotates the stored word (Te3) to produce Te0..Te3 and returns the
//   result tagged with the requester index, in grant order.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      tbox_lookup_arbiter_if.slave (requests, ROM, responses, counter)
// Parameters:
//   N        number of requesters (2..8)
//   ID_W     requester index width, ceil(log2(N))
//   OUT_REG  0: response one cycle after grant, 1: two cycles after grant
module tbox_lookup_arbiter #(
  parameter int N       = 4,
  parameter int ID_W    = 2,
  parameter bit OUT_REG = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  tbox_lookup_arbiter_if.slave   bus
);

  localparam logic [ID_W:0]   NUM_REQ = (ID_W+1)'(N);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(N-1);

  // Stored word is Te3; rotating right by 8*rot yields Te3, Te0, Te1, Te2.
  function automatic logic [31:0] rotr8(input logic [31:0] w, input logic [1:0] r);
    logic [31:0] v;
    case (r)
      2'd0:    v = w;
      2'd1:    v = {w[7:0],  w[31:8]};
      2'd2:    v = {w[15:0], w[31:16]};
      default: v = {w[23:0], w[31:24]};
    endcase
    return v;
  endfunction

  logic              w_found;
  logic [ID_W-1:0]   w_gnt_id;
  logic [ID_W:0]     w_sum;
  logic [N-1:0]      w_grant;
  logic [7:0]        w_sel_addr;
  logic [1:0]        w_sel_rot;
  logic [31:0]       w_rot_data;

  logic [ID_W-1:0]   r_ptr;
  logic [7:0]        r_rom_addr;
  logic              r_s1_valid;
  logic [ID_W-1:0]   r_s1_id;
  logic [1:0]        r_s1_rot;
  logic [ID_W-1:0]   r_out_id;
  logic [31:0]       r_out_data;
  logic [15:0]       r_count;

  // Search from the pointer upward, wrapping at N. Gating with reset_n keeps
  // req_ready low while reset is held.
  always_comb begin
    w_found  = 1'b0;
    w_gnt_id = '0;
    w_sum    = '0;
    if (reset_n && bus.en) begin
      for (int k = 0; k < N; k++) begin
        w_sum = {1'b0, r_ptr} + (ID_W+1)'(k);
        if (w_sum >= NUM_REQ) w_sum = w_sum - NUM_REQ;
        if (!w_found && bus.req_valid[w_sum[ID_W-1:0]]) begin
          w_found  = 1'b1;
          w_gnt_id = w_sum[ID_W-1:0];
        end
      end
    end
  end

  always_comb begin
    w_grant = '0;
    if (w_found) w_grant[w_gnt_id] = 1'b1;
  end

  assign bus.req_ready = w_grant;
  assign w_sel_addr    = bus.req_addr[{w_gnt_id, 3'b000} +: 8];
  assign w_sel_rot     = bus.req_rot[{w_gnt_id, 1'b0} +: 2];

  // Hold the last granted address when idle so the ROM input does not toggle.
  assign bus.rom_addr  = w_found ? w_sel_addr : r_rom_addr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr      <= '0;
      r_rom_addr <= '0;
      r_s1_valid <= 1'b0;
      r_s1_id    <= '0;
      r_s1_rot   <= '0;
    end else begin
      r_s1_valid <= w_found;
      if (w_found) begin
        r_ptr      <= (w_gnt_id == LAST_ID) ? '0 : w_gnt_id + 1'b1;
        r_rom_addr <= w_sel_addr;
        r_s1_id    <= w_gnt_id;
        r_s1_rot   <= w_sel_rot;
      end
    end
  end

  assign w_rot_data = rotr8(bus.rom_q, r_s1_rot);

  // Last delivered id/data; serves as the idle hold value when OUT_REG=0 and
  // as the output register when OUT_REG=1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_id   <= '0;
      r_out_data <= '0;
    end else if (r_s1_valid) begin
      r_out_id   <= r_s1_id;
      r_out_data <= w_rot_data;
    end
  end

  generate
    if (OUT_REG) begin : gen_out_reg
      logic r_out_valid;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_out_valid <= 1'b0;
        else          r_out_valid <= r_s1_valid;
      end
      assign bus.rsp_valid = r_out_valid;
      assign bus.rsp_id    = r_out_id;
      assign bus.rsp_data  = r_out_data;
    end else begin : gen_out_comb
      assign bus.rsp_valid = r_s1_valid;
      assign bus.rsp_id    = r_s1_valid ? r_s1_id    : r_out_id;
      assign bus.rsp_data  = r_s1_valid ? w_rot_data : r_out_data;
    end
  endgenerate

  // Clear wins over a same-cycle grant; the count sticks at all-ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                              r_count <= '0;
    else if (bus.stat_clr)                     r_count <= '0;
    else if (w_found && r_count != 16'hFFFF)   r_count <= r_count + 16'd1;
  end

  assign bus.lookup_count = r_count;

endmodule
